// File: rtl/uart_rx_pkt_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : uart_pkt_pkg                                                   |
// | Purpose : Shared constants, FSM state type and flit field offsets for    |
// |           the UART RX packet controller.                                 |
// | Contents: HDR_* legal header codes, state_t, FLIT_*_LSB offsets,         |
// |           hdr_legal() helper.                                            |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package uart_pkt_pkg;

  localparam logic [7:0] HDR_LOOPBACK = 8'h00;
  localparam logic [7:0] HDR_BOOT     = 8'h01;
  localparam logic [7:0] HDR_SCANF    = 8'h03;

  // Header flit layout: {hdr, addr, size}
  localparam int FLIT_HDR_LSB  = 24;
  localparam int FLIT_ADDR_LSB = 16;
  localparam int FLIT_SIZE_LSB = 0;

  typedef enum logic [2:0] {
    S_HDR     = 3'd0,
    S_ADDR    = 3'd1,
    S_SZ_LO   = 3'd2,
    S_SZ_HI   = 3'd3,
    S_PAYLOAD = 3'd4,
    S_DRAIN   = 3'd5,
    S_ABORT   = 3'd6
  } state_t;

  function automatic logic hdr_legal(input logic [7:0] h);
    return (h == HDR_LOOPBACK) || (h == HDR_BOOT) || (h == HDR_SCANF);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_pkt_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : uart_rx_pkt_ctrl_if                                            |
// | Purpose : Byte-in / flit-out bus of the UART RX packet controller.       |
// | Signals : rx_valid/rx_data (byte strobe from UART deserializer),         |
// |           flit_valid/flit_ready/flit_data/flit_last/dest_addr (NoC side) |
// | Modports: master = byte source and flit sink, slave = the controller.    |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface uart_rx_pkt_ctrl_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        flit_valid;
  logic        flit_ready;
  logic [31:0] flit_data;
  logic        flit_last;
  logic [7:0]  dest_addr;

  modport master (
    output rx_valid, rx_data, flit_ready,
    input  flit_valid, flit_data, flit_last, dest_addr
  );

  modport slave (
    input  rx_valid, rx_data, flit_ready,
    output flit_valid, flit_data, flit_last, dest_addr
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_pkt_ctrl_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : uart_byte_packer                                               |
// | Purpose : 4-lane little-endian byte accumulator.                         |
// | Ports   : clk, rst        clock / async active-high reset                |
// |           i_clear         drop accumulated bytes, lane back to 0         |
// |           i_push,i_byte   accept one byte into the current lane          |
// |           i_flush         with i_push: this byte completes the word      |
// |           o_lane          current lane (0..3)                            |
// |           o_word          accumulated bytes plus i_byte, upper lanes 0   |
// |           o_partial       accumulated bytes only, upper lanes 0          |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module uart_byte_packer (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        i_clear,
  input  wire logic        i_push,
  input  wire logic        i_flush,
  input  wire logic [7:0]  i_byte,
  output logic [1:0]       o_lane,
  output logic [31:0]      o_word,
  output logic [31:0]      o_partial
);
  logic [1:0]  r_lane;
  logic [23:0] r_buf;   // lanes 0..2; lanes at or above r_lane are kept zero

  always_comb begin
    o_partial = {8'h00, r_buf};
    o_word    = o_partial;
    o_word[{r_lane, 3'b000} +: 8] = i_byte;
  end

  assign o_lane = r_lane;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane <= 2'd0;
      r_buf  <= 24'd0;
    end else if (i_clear || (i_push && i_flush)) begin
      r_lane <= 2'd0;
      r_buf  <= 24'd0;
    end else if (i_push) begin
      r_buf  <= o_word[23:0];
      r_lane <= r_lane + 2'd1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/uart_rx_pkt_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : uart_rx_pkt_ctrl                                               |
// | Purpose : Parses HEADER/NOC_ADDR/SIZE(LE16)/PAYLOAD byte packets from    |
// |           the UART receiver into one header flit plus payload flits.     |
// | Ports   : clk, rst            clock / async active-high reset            |
// |           bus (slave)         byte input and flit output handshake       |
// |           i_err_clear         clears sticky errors (set wins)            |
// |           o_busy              high outside S_HDR                         |
// |           o_err_bad_header    illegal header code or SIZE > MAX_SIZE     |
// |           o_err_overrun       flit lost to a full output register        |
// |           o_err_timeout       inter-byte timeout fired mid-packet        |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module uart_rx_pkt_ctrl
  import uart_pkt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int MAX_SIZE       = 4096
) (
  input  wire logic          clk,
  input  wire logic          rst,
  uart_rx_pkt_ctrl_if.slave  bus,
  input  wire logic          i_err_clear,
  output logic               o_busy,
  output logic               o_err_bad_header,
  output logic               o_err_overrun,
  output logic               o_err_timeout
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        r_state, w_next;
  logic [7:0]    r_hdr, r_addr, r_size_lo, r_dest;
  logic [15:0]   r_remain;
  logic [TW-1:0] r_tmo;
  logic          r_flit_valid, r_flit_last;
  logic [31:0]   r_flit_data;
  logic          r_err_bad, r_err_ovr, r_err_tmo;

  logic          w_rx, w_full, w_good, w_tmo_hit, w_final;
  logic [15:0]   w_size;
  logic [1:0]    w_lane;
  logic [31:0]   w_pack_word, w_part_word;
  logic          w_load, w_load_last, w_push, w_flush, w_pclear;
  logic [31:0]   w_load_data;
  logic          w_set_bad, w_set_ovr, w_set_tmo, w_remain_ld, w_remain_dec;

  assign w_rx      = bus.rx_valid;
  // A held flit being accepted this cycle frees the register for a new load.
  assign w_full    = r_flit_valid & ~bus.flit_ready;
  assign w_size    = {bus.rx_data, r_size_lo};
  assign w_good    = hdr_legal(r_hdr) && ({16'd0, w_size} <= 32'(MAX_SIZE));
  // A byte arriving on the expiry cycle wins over the timeout.
  assign w_tmo_hit = !w_rx && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign w_final   = (r_remain == 16'd1);

  uart_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_pclear),
    .i_push    (w_push),
    .i_flush   (w_flush),
    .i_byte    (bus.rx_data),
    .o_lane    (w_lane),
    .o_word    (w_pack_word),
    .o_partial (w_part_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_HDR;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_load       = 1'b0;
    w_load_data  = 32'd0;
    w_load_last  = 1'b0;
    w_push       = 1'b0;
    w_flush      = 1'b0;
    w_pclear     = 1'b0;
    w_set_bad    = 1'b0;
    w_set_ovr    = 1'b0;
    w_set_tmo    = 1'b0;
    w_remain_ld  = 1'b0;
    w_remain_dec = 1'b0;
    case (r_state)
      S_HDR: if (w_rx) w_next = S_ADDR;
      S_ADDR, S_SZ_LO: begin
        if (w_rx) begin
          w_next = (r_state == S_ADDR) ? S_SZ_LO : S_SZ_HI;
        end else if (w_tmo_hit) begin
          w_set_tmo = 1'b1;
          w_next    = S_HDR;
        end
      end
      S_SZ_HI: begin
        if (w_rx) begin
          w_remain_ld = 1'b1;
          if (w_good) begin
            w_load      = 1'b1;
            w_load_data = {r_hdr, r_addr, w_size};
            w_load_last = (w_size == 16'd0);
            w_next      = (w_size == 16'd0) ? S_HDR : S_PAYLOAD;
          end else begin
            w_set_bad = 1'b1;
            w_next    = (w_size == 16'd0) ? S_HDR : S_DRAIN;
          end
        end else if (w_tmo_hit) begin
          w_set_tmo = 1'b1;
          w_next    = S_HDR;
        end
      end
      S_PAYLOAD: begin
        if (w_rx) begin
          w_push       = 1'b1;
          w_remain_dec = 1'b1;
          w_flush      = (w_lane == 2'd3) || w_final;
          if (w_flush) begin
            w_load      = 1'b1;
            w_load_data = w_pack_word;
            w_load_last = w_final;
          end
          if (w_final) w_next = S_HDR;
        end else if (w_tmo_hit) begin
          w_set_tmo = 1'b1;
          w_next    = S_ABORT;
        end
      end
      S_DRAIN: begin
        if (w_rx) begin
          w_remain_dec = 1'b1;
          if (w_final) w_next = S_HDR;
        end else if (w_tmo_hit) begin
          w_set_tmo = 1'b1;
          w_next    = S_HDR;
        end
      end
      S_ABORT: begin
        if (w_rx) w_set_ovr = 1'b1;
        if (!w_full) begin
          w_load      = 1'b1;
          w_load_data = w_part_word;
          w_load_last = 1'b1;
          w_pclear    = 1'b1;
          w_next      = S_HDR;
        end
      end
      default: w_next = S_HDR;
    endcase
    // A flit that finds the register full is lost; the rest of the packet
    // is swallowed so the NoC never sees a half packet followed by garbage.
    if (w_load && w_full) begin
      w_set_ovr = 1'b1;
      if (w_next == S_PAYLOAD) w_next = S_DRAIN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hdr        <= 8'd0;
      r_addr       <= 8'd0;
      r_size_lo    <= 8'd0;
      r_dest       <= 8'd0;
      r_remain     <= 16'd0;
      r_tmo        <= '0;
      r_flit_valid <= 1'b0;
      r_flit_data  <= 32'd0;
      r_flit_last  <= 1'b0;
      r_err_bad    <= 1'b0;
      r_err_ovr    <= 1'b0;
      r_err_tmo    <= 1'b0;
    end else begin
      if (w_rx && r_state == S_HDR)   r_hdr     <= bus.rx_data;
      if (w_rx && r_state == S_ADDR)  r_addr    <= bus.rx_data;
      if (w_rx && r_state == S_SZ_LO) r_size_lo <= bus.rx_data;

      if (w_remain_ld)       r_remain <= w_size;
      else if (w_remain_dec) r_remain <= r_remain - 16'd1;

      if (w_rx || r_state == S_HDR || r_state == S_ABORT) r_tmo <= '0;
      else                                                r_tmo <= r_tmo + 1'b1;

      if (w_load && !w_full) begin
        r_flit_valid <= 1'b1;
        r_flit_data  <= w_load_data;
        r_flit_last  <= w_load_last;
        if (r_state == S_SZ_HI) r_dest <= r_addr;
      end else if (r_flit_valid && bus.flit_ready) begin
        r_flit_valid <= 1'b0;
      end

      r_err_bad <= w_set_bad | (r_err_bad & ~i_err_clear);
      r_err_ovr <= w_set_ovr | (r_err_ovr & ~i_err_clear);
      r_err_tmo <= w_set_tmo | (r_err_tmo & ~i_err_clear);
    end
  end

  assign bus.flit_valid = r_flit_valid;
  assign bus.flit_data  = r_flit_data;
  assign bus.flit_last  = r_flit_last;
  assign bus.dest_addr  = r_dest;

  assign o_busy           = (r_state != S_HDR);
  assign o_err_bad_header = r_err_bad;
  assign o_err_overrun    = r_err_ovr;
  assign o_err_timeout    = r_err_tmo;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_pkt_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_uart_rx_pkt_ctrl                                            |
// | Purpose : Self-checking bench for uart_rx_pkt_ctrl: packet-level model   |
// |           feeding a flit scoreboard, plus literal flit/error checks.     |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_uart_rx_pkt_ctrl;
  localparam int TMO  = 20;
  localparam int MAXS = 8;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [7:0]  dest;
  } flit_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_clear = 1'b0;
  logic busy, e_bad, e_ovr, e_tmo;

  uart_rx_pkt_ctrl_if bus();

  uart_rx_pkt_ctrl #(.TIMEOUT_CYCLES(TMO), .MAX_SIZE(MAXS)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .i_err_clear      (err_clear),
    .o_busy           (busy),
    .o_err_bad_header (e_bad),
    .o_err_overrun    (e_ovr),
    .o_err_timeout    (e_tmo)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  flit_t       exp_q[$];
  logic [31:0] got_d[$];
  logic        got_l[$];
  logic [7:0]  pkt[$];
  logic        x_bad = 1'b0, x_ovr = 1'b0, x_tmo = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level model: derives the flit list from the packet bytes.
  // hold_ready: sink never accepts, so only the first flit can be stored.
  // sent: payload bytes delivered before the line goes silent.
  task automatic model_pkt(input bit hold_ready, input int sent);
    logic [7:0]  hdr, addr;
    int          size;
    logic [31:0] w;
    bit          aborted;
    hdr  = pkt[0];
    addr = pkt[1];
    size = int'(pkt[2]) + 256 * int'(pkt[3]);
    if (!(hdr == 8'd0 || hdr == 8'd1 || hdr == 8'd3) || size > MAXS) begin
      x_bad = 1'b1;
      return;
    end
    exp_q.push_back('{data: {hdr, addr, 16'(size)}, last: (size == 0), dest: addr});
    if (size == 0) return;
    if (hold_ready) begin
      x_ovr = 1'b1;
      return;
    end
    aborted = (sent < size);
    for (int i = 0; i < sent; i += 4) begin
      w = 32'd0;
      for (int j = 0; j < 4; j++)
        if (i + j < sent) w = w | (32'(pkt[4 + i + j]) << (8 * j));
      exp_q.push_back('{data: w, last: (i + 4 >= (aborted ? sent : size)) &&
                        !(aborted && (sent % 4 == 0)), dest: addr});
    end
    if (aborted) begin
      if (sent % 4 == 0) exp_q.push_back('{data: 32'd0, last: 1'b1, dest: addr});
      x_tmo = 1'b1;
    end
  endtask

  task automatic send_pkt();
    foreach (pkt[i]) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = pkt[i];
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_errs(input string tag);
    check({tag, "_err_bad"}, 32'(e_bad), 32'(x_bad));
    check({tag, "_err_ovr"}, 32'(e_ovr), 32'(x_ovr));
    check({tag, "_err_tmo"}, 32'(e_tmo), 32'(x_tmo));
  endtask

  task automatic clear_errs();
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    x_bad = 1'b0; x_ovr = 1'b0; x_tmo = 1'b0;
  endtask

  // Scoreboard: every accepted flit is checked against the model.
  always @(negedge clk) begin
    if (!rst && bus.flit_valid && bus.flit_ready) begin
      got_d.push_back(bus.flit_data);
      got_l.push_back(bus.flit_last);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_flit: got %h, none expected", bus.flit_data);
      end else begin
        flit_t e;
        e = exp_q.pop_front();
        check("sb_flit_data", bus.flit_data, e.data);
        check("sb_flit_last", 32'(bus.flit_last), 32'(e.last));
        check("sb_dest_addr", 32'(bus.dest_addr), 32'(e.dest));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    bus.rx_valid   = 1'b0;
    bus.rx_data    = 8'd0;
    bus.flit_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // Reset state
    check("rst_flit_valid", 32'(bus.flit_valid), 32'd0);
    check("rst_flit_data", bus.flit_data, 32'd0);
    check("rst_flit_last", 32'(bus.flit_last), 32'd0);
    check("rst_dest", 32'(bus.dest_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check_errs("rst");

    // SIZE==MAX_SIZE, two full payload words
    pkt = '{8'h03, 8'h08, 8'h08, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01,
            8'h08, 8'h07, 8'h06, 8'h05};
    b = got_d.size();
    model_pkt(1'b0, 8);
    send_pkt();
    wait_drain();
    check("t1_nflits", 32'(got_d.size() - b), 32'd3);
    check("t1_f0", got_d[b], 32'h0308_0008);
    check("t1_f1", got_d[b + 1], 32'h0102_0304);
    check("t1_f2", got_d[b + 2], 32'h0506_0708);
    check("t1_f2_last", 32'(got_l[b + 2]), 32'd1);
    check("t1_dest", 32'(bus.dest_addr), 32'h08);

    // SIZE==0: header flit carries last, one cycle after final byte
    pkt = '{8'h01, 8'h05, 8'h00, 8'h00};
    model_pkt(1'b0, 0);
    send_pkt();
    check("t2_valid_latency", 32'(bus.flit_valid), 32'd1);
    check("t2_data", bus.flit_data, 32'h0105_0000);
    check("t2_last", 32'(bus.flit_last), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    wait_drain();

    // Illegal header code: drained silently
    pkt = '{8'h02, 8'h01, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33};
    b = got_d.size();
    model_pkt(1'b0, 3);
    send_pkt();
    idle(3);
    check("t4_nflits", 32'(got_d.size() - b), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_bad_literal", 32'(e_bad), 32'd1);
    check_errs("t4");
    clear_errs();
    check_errs("t4_clr");

    // Partial final word zero-padded
    pkt = '{8'h00, 8'h02, 8'h05, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    b = got_d.size();
    model_pkt(1'b0, 5);
    send_pkt();
    wait_drain();
    check("t3_nflits", 32'(got_d.size() - b), 32'd3);
    check("t3_f0", got_d[b], 32'h0002_0005);
    check("t3_f1", got_d[b + 1], 32'hDDCC_BBAA);
    check("t3_f2", got_d[b + 2], 32'h0000_00EE);
    check_errs("t3");

    // SIZE one above MAX_SIZE is bad
    pkt = '{8'h01, 8'h00, 8'h09, 8'h00};
    for (int i = 0; i < 9; i++) pkt.push_back(8'(i));
    b = got_d.size();
    model_pkt(1'b0, 9);
    send_pkt();
    idle(3);
    check("tmax_nflits", 32'(got_d.size() - b), 32'd0);
    check("tmax_busy", 32'(busy), 32'd0);
    check_errs("tmax");
    clear_errs();

    // Sink stalled: header held, payload flit lost, rest drained
    bus.flit_ready = 1'b0;
    pkt = '{8'h01, 8'h09, 8'h08, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40,
            8'h50, 8'h60, 8'h70, 8'h80};
    b = got_d.size();
    model_pkt(1'b1, 8);
    send_pkt();
    idle(3);
    check("t5_held_valid", 32'(bus.flit_valid), 32'd1);
    check("t5_held_data", bus.flit_data, 32'h0109_0008);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_ovr_literal", 32'(e_ovr), 32'd1);
    check_errs("t5");
    bus.flit_ready = 1'b1;
    wait_drain();
    idle(3);
    check("t5_nflits", 32'(got_d.size() - b), 32'd1);
    check("t5_valid_after", 32'(bus.flit_valid), 32'd0);
    clear_errs();

    // Timeout mid-payload: partial word flushed with last
    pkt = '{8'h03, 8'h08, 8'h08, 8'h00, 8'h11, 8'h22};
    b = got_d.size();
    model_pkt(1'b0, 2);
    send_pkt();
    idle(TMO + 5);
    wait_drain();
    check("t6_nflits", 32'(got_d.size() - b), 32'd2);
    check("t6_abort_flit", got_d[b + 1], 32'h0000_2211);
    check("t6_abort_last", 32'(got_l[b + 1]), 32'd1);
    check("t6_tmo_literal", 32'(e_tmo), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    check_errs("t6");
    clear_errs();
    check("t6_tmo_cleared", 32'(e_tmo), 32'd0);

    // Timeout while waiting for NOC_ADDR
    pkt = '{8'h01};
    send_pkt();
    check("t7_busy_mid", 32'(busy), 32'd1);
    idle(TMO + 5);
    x_tmo = 1'b1;
    check("t7_busy", 32'(busy), 32'd0);
    check_errs("t7");
    clear_errs();
    check_errs("t7_clr");

    check("final_exp_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
